rpm_pid_controller: RTL and testbench

//  Closed-loop speed stage fed by the tachometer stage's 10-bit RPM value.
//  - Samples measured RPM once per 10 ms window and computes a fixed-point PID update.
//  - Uses one shared multiplier in a multi-cycle FSM.
//  - Drives the H-bridge enable through an internal PWM generator.

---
 rtl/rpm_pid_pkg.sv | 32 +++
 rtl/rpm_pid_if.sv | 22 ++
 rtl/rpm_pid_controller_pwm.sv | 60 ++++++
 rtl/rpm_pid_controller.sv | 155 +++++++++++++++
 tb/tb_rpm_pid_controller.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpm_pid_pkg.sv
// Shared types, widths and helpers for the RPM PID speed controller.
package rpm_pid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC_ERR,
    MUL_P,
    MUL_I,
    MUL_D,
    SATURATE
  } pid_state_e;

  localparam int ERR_W     = 11;
  localparam int DERIV_W   = 12;
  localparam int ACC_W     = 32;
  localparam int INTEG_W   = 16;
  localparam int FRAC_BITS = 8;
  localparam int DUTY_MAX  = 255;
  localparam int GAIN_W    = 16;
  localparam int RPM_W     = 10;
  localparam int DUTY_W    = 8;

  // Drop the Q8.8 fraction (floor) and clip the result into the duty range.
  function automatic logic [DUTY_W-1:0] sat_duty(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] u;
    u = acc >>> FRAC_BITS;
    if (u < 0)             return '0;
    else if (u > DUTY_MAX) return DUTY_W'(DUTY_MAX);
    else                   return u[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/rpm_pid_if.sv
// Control-side signal bundle of the speed controller: setpoint/measurement in, duty/PWM out.
interface rpm_pid_if;
  import rpm_pid_pkg::*;

  logic              enable_in;
  logic [RPM_W-1:0]  target_rpm_in;
  logic [RPM_W-1:0]  actual_rpm_in;
  logic [DUTY_W-1:0] duty_out;
  logic              duty_valid_out;
  logic              pwm_out;

  modport master (
    output enable_in, target_rpm_in, actual_rpm_in,
    input  duty_out, duty_valid_out, pwm_out
  );

  modport slave (
    input  enable_in, target_rpm_in, actual_rpm_in,
    output duty_out, duty_valid_out, pwm_out
  );

endinterface

// File: rtl/rpm_pid_controller_pwm.sv
// 8-bit PWM generator: prescaled counter, duty shadowed at wrap, registered compare output.
module pwm_generator #(
  parameter int PWM_DIV = 20
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic       enable_in,
  input  logic [7:0] duty_in,
  output logic       pwm_out
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       shadow_q, shadow_d;
  logic             pwm_q, pwm_d;
  logic             step;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    step     = (pre_q == PRE_LAST);
    pre_d    = step ? '0 : pre_q + 1'b1;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    pwm_d    = (cnt_q < shadow_q);

    if (step) begin
      cnt_d = cnt_q + 8'd1;
      // New duty only takes effect at the start of a period, so no runt pulses.
      if (cnt_q == 8'hFF) shadow_d = duty_in;
    end

    if (!enable_in) begin
      pre_d    = '0;
      cnt_d    = '0;
      shadow_d = '0;
      pwm_d    = 1'b0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/rpm_pid_controller.sv
// Sampled PID speed loop: period counter, one-multiplier PID FSM, duty saturation and PWM drive.
module rpm_pid_controller
  import rpm_pid_pkg::*;
#(
  parameter int unsigned              SAMPLE_CYCLES = 1250000,
  parameter logic signed [GAIN_W-1:0] KP            = 16'sh0100,
  parameter logic signed [GAIN_W-1:0] KI            = 16'sh0010,
  parameter logic signed [GAIN_W-1:0] KD            = 16'sh0000,
  parameter int                       INTEG_LIMIT   = 4096,
  parameter int                       PWM_DIV       = 20
) (
  input  logic     clk_in,
  input  logic     reset_n_in,
  rpm_pid_if.slave bus
);

  localparam int                      CNT_W    = $clog2(SAMPLE_CYCLES);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic signed [INTEG_W:0] LIM_POS  = (INTEG_W+1)'(INTEG_LIMIT);
  localparam logic signed [INTEG_W:0] LIM_NEG  = -LIM_POS;

  pid_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic signed [ERR_W-1:0]    err_q, err_d;
  logic signed [ERR_W-1:0]    prev_err_q, prev_err_d;
  logic signed [DERIV_W-1:0]  deriv_q, deriv_d;
  logic signed [INTEG_W-1:0]  integ_q, integ_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [DUTY_W-1:0]          duty_q, duty_d;
  logic                       duty_valid_q, duty_valid_d;

  logic                       tick;
  logic signed [ERR_W-1:0]    err_now;
  logic signed [INTEG_W:0]    integ_sum;
  logic signed [INTEG_W-1:0]  integ_sat;
  logic signed [GAIN_W-1:0]   mul_a, mul_b;
  logic signed [ACC_W-1:0]    product;

  assign tick    = (cnt_q == CNT_LAST);
  assign err_now = $signed({1'b0, bus.target_rpm_in} - {1'b0, bus.actual_rpm_in});

  // One extra bit of headroom lets the clamp see the true sum before it is narrowed.
  always_comb begin
    integ_sum = (INTEG_W+1)'(integ_q) + (INTEG_W+1)'(err_q);
    if (integ_sum > LIM_POS)      integ_sat = LIM_POS[INTEG_W-1:0];
    else if (integ_sum < LIM_NEG) integ_sat = LIM_NEG[INTEG_W-1:0];
    else                          integ_sat = integ_sum[INTEG_W-1:0];
  end

  // Operand select for the single shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MUL_P: begin mul_a = GAIN_W'(err_q);   mul_b = KP; end
      MUL_I: begin mul_a = integ_sat;        mul_b = KI; end
      MUL_D: begin mul_a = GAIN_W'(deriv_q); mul_b = KD; end
      default: ;
    endcase
  end

  assign product = ACC_W'(mul_a) * ACC_W'(mul_b);

  always_comb begin
    state_d      = state_q;
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    err_d        = err_q;
    prev_err_d   = prev_err_q;
    deriv_d      = deriv_q;
    integ_d      = integ_q;
    acc_d        = acc_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;

    case (state_q)
      IDLE:     if (tick) state_d = CALC_ERR;
      CALC_ERR: begin
        err_d      = err_now;
        deriv_d    = DERIV_W'(err_now) - DERIV_W'(prev_err_q);
        prev_err_d = err_now;
        state_d    = MUL_P;
      end
      MUL_P: begin
        acc_d   = product;
        state_d = MUL_I;
      end
      MUL_I: begin
        integ_d = integ_sat;
        acc_d   = acc_q + product;
        state_d = MUL_D;
      end
      MUL_D: begin
        acc_d   = acc_q + product;
        state_d = SATURATE;
      end
      SATURATE: begin
        duty_d       = sat_duty(acc_q);
        duty_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Disable wins over everything, including a computation in flight.
    if (!bus.enable_in) begin
      state_d      = IDLE;
      cnt_d        = '0;
      err_d        = '0;
      prev_err_d   = '0;
      deriv_d      = '0;
      integ_d      = '0;
      acc_d        = '0;
      duty_d       = '0;
      duty_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_q        <= '0;
      prev_err_q   <= '0;
      deriv_q      <= '0;
      integ_q      <= '0;
      acc_q        <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      prev_err_q   <= prev_err_d;
      deriv_q      <= deriv_d;
      integ_q      <= integ_d;
      acc_q        <= acc_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
    end
  end

  assign bus.duty_out       = duty_q;
  assign bus.duty_valid_out = duty_valid_q;

  pwm_generator #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .enable_in  (bus.enable_in),
    .duty_in    (duty_q),
    .pwm_out    (bus.pwm_out)
  );

endmodule

// File: tb/tb_rpm_pid_controller.sv
// Five controllers with different gain sets run in lock-step against an integer PID reference model.
module tb_rpm_pid_controller;

  localparam int N_DUT  = 5;
  localparam int SAMPLE = 16;

  // 0: P only, 1: I only, 2: I only with tight clamp, 3: D only, 4: mixed gains
  function automatic logic signed [15:0] kp_of(input int i);
    case (i)
      0:       return 16'sh0100;
      4:       return 16'sh0180;
      default: return 16'sh0000;
    endcase
  endfunction

  function automatic logic signed [15:0] ki_of(input int i);
    case (i)
      1, 2:    return 16'sh0100;
      4:       return 16'sh0030;
      default: return 16'sh0000;
    endcase
  endfunction

  function automatic logic signed [15:0] kd_of(input int i);
    case (i)
      3:       return 16'sh0100;
      4:       return 16'sh0040;
      default: return 16'sh0000;
    endcase
  endfunction

  function automatic int lim_of(input int i);
    case (i)
      2:       return 25;
      4:       return 500;
      default: return 4096;
    endcase
  endfunction

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [9:0] tgt   [N_DUT];
  logic [9:0] act   [N_DUT];
  logic [7:0] duty  [N_DUT];
  logic       valid [N_DUT];
  logic       pwm   [N_DUT];

  int integ_m [N_DUT];
  int prev_m  [N_DUT];
  int pwm_hi  [N_DUT];
  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    rpm_pid_if bus ();
    assign bus.enable_in     = en;
    assign bus.target_rpm_in = tgt[g];
    assign bus.actual_rpm_in = act[g];
    assign duty[g]           = bus.duty_out;
    assign valid[g]          = bus.duty_valid_out;
    assign pwm[g]            = bus.pwm_out;

    rpm_pid_controller #(
      .SAMPLE_CYCLES (SAMPLE),
      .KP            (kp_of(g)),
      .KI            (ki_of(g)),
      .KD            (kd_of(g)),
      .INTEG_LIMIT   (lim_of(g)),
      .PWM_DIV       (1)
    ) u_dut (
      .clk_in     (clk),
      .reset_n_in (rst_n),
      .bus        (bus)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: one PID update from the current setpoint/measurement, in plain integers.
  function automatic int model_step(input int i);
    int err, deriv, acc, u;
    err        = int'(tgt[i]) - int'(act[i]);
    deriv      = err - prev_m[i];
    prev_m[i]  = err;
    integ_m[i] = integ_m[i] + err;
    if (integ_m[i] > lim_of(i))  integ_m[i] = lim_of(i);
    if (integ_m[i] < -lim_of(i)) integ_m[i] = -lim_of(i);
    acc = err * int'(kp_of(i)) + integ_m[i] * int'(ki_of(i)) + deriv * int'(kd_of(i));
    u   = acc >>> 8;
    if (u < 0)   return 0;
    if (u > 255) return 255;
    return u;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N_DUT; i++) begin
      integ_m[i] = 0;
      prev_m[i]  = 0;
    end
  endtask

  task automatic set_in(input int i, input int t, input int a);
    tgt[i] = 10'(t);
    act[i] = 10'(a);
  endtask

  task automatic randomize_in(input int i);
    tgt[i] = 10'($urandom_range(0, 1023));
    act[i] = 10'($urandom_range(0, 1023));
  endtask

  // Waits (bounded) for the next duty_valid pulse and checks every controller against the model.
  task automatic wait_tick(input int exp_gap, input string tag);
    int  gap;
    int  stray;
    bit  seen;
    gap   = 0;
    stray = 0;
    seen  = 1'b0;
    while (!seen && gap < 100) begin
      @(posedge clk);
      @(negedge clk);
      gap++;
      for (int i = 0; i < N_DUT; i++) pwm_hi[i] += int'(pwm[i]);
      if (valid[0]) seen = 1'b1;
      else for (int i = 0; i < N_DUT; i++) if (valid[i]) stray++;
    end
    check($sformatf("%s_gap", tag), gap, exp_gap);
    check($sformatf("%s_stray", tag), stray, 0);
    if (seen) begin
      for (int i = 0; i < N_DUT; i++) begin
        check($sformatf("%s_valid%0d", tag, i), 32'(valid[i]), 1);
        check($sformatf("%s_duty%0d", tag, i), 32'(duty[i]), model_step(i));
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("%s_duty%0d", tag, i), 32'(duty[i]), 0);
      check($sformatf("%s_valid%0d", tag, i), 32'(valid[i]), 0);
      check($sformatf("%s_pwm%0d", tag, i), 32'(pwm[i]), 0);
    end
  endtask

  task automatic pwm_window(input string tag);
    for (int k = 0; k < 32; k++) begin
      randomize_in(4);
      wait_tick(SAMPLE, $sformatf("%s_settle", tag));
    end
    for (int i = 0; i < N_DUT; i++) pwm_hi[i] = 0;
    for (int k = 0; k < 16; k++) begin
      randomize_in(4);
      wait_tick(SAMPLE, $sformatf("%s_win", tag));
    end
  endtask

  initial begin
    int pulses;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    for (int i = 0; i < N_DUT; i++) begin
      set_in(i, 0, 0);
      pwm_hi[i] = 0;
    end
    clear_model();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Directed ticks: P, I, clamped I, D scenarios side by side.
    set_in(0, 300, 200); set_in(1, 110, 100); set_in(2, 110, 100); set_in(3, 200, 200);
    randomize_in(4);
    en = 1'b1;
    wait_tick(SAMPLE + 5, "t1");
    check("p_basic", 32'(duty[0]), 100);
    check("i_1", 32'(duty[1]), 10);
    check("il_1", 32'(duty[2]), 10);
    check("d_flat", 32'(duty[3]), 0);

    set_in(0, 1000, 0); set_in(3, 200, 150); randomize_in(4);
    wait_tick(SAMPLE, "t2");
    check("p_sat_hi", 32'(duty[0]), 255);
    check("i_2", 32'(duty[1]), 20);
    check("il_2", 32'(duty[2]), 20);
    check("d_step", 32'(duty[3]), 50);

    set_in(0, 0, 500); randomize_in(4);
    wait_tick(SAMPLE, "t3");
    check("p_sat_lo", 32'(duty[0]), 0);
    check("i_3", 32'(duty[1]), 30);
    check("il_clamp", 32'(duty[2]), 25);
    check("d_settle", 32'(duty[3]), 0);

    set_in(0, 164, 100); randomize_in(4);
    wait_tick(SAMPLE, "t4");
    check("p_64", 32'(duty[0]), 64);
    check("il_hold", 32'(duty[2]), 25);

    // PWM duty measured over exactly one 256-clock period.
    pwm_window("pwm64");
    check("pwm_hi_64", pwm_hi[0], 64);
    check("pwm_hi_25", pwm_hi[2], 25);
    check("pwm_hi_0", pwm_hi[3], 0);

    set_in(0, 1000, 0);
    pwm_window("pwm255");
    check("pwm_hi_255", pwm_hi[0], 255);

    // Random setpoints and measurements for every controller.
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < N_DUT; i++) randomize_in(i);
      wait_tick(SAMPLE, "rnd");
    end

    // Disable while the next update is in its integrator step.
    set_in(0, 1000, 0); set_in(1, 110, 100); set_in(2, 110, 100); set_in(3, 200, 150);
    repeat (13) @(posedge clk);
    @(negedge clk);
    en     = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < N_DUT; i++) if (valid[i]) pulses++;
    end
    check("dis_no_pulse", pulses, 0);
    repeat (260) @(negedge clk);
    check_outputs_zero("dis");
    clear_model();

    // Re-enable: integrator restarts from zero, first tick a full period later.
    en = 1'b1;
    wait_tick(SAMPLE + 5, "re1");
    check("i_restart_1", 32'(duty[1]), 10);
    wait_tick(SAMPLE, "re2");
    check("i_restart_2", 32'(duty[1]), 20);
    wait_tick(SAMPLE, "re3");
    check("i_restart_3", 32'(duty[1]), 30);
    check("p_pre_reset", 32'(duty[0]), 255);

    // Asynchronous reset in the middle of an update, away from any clock edge.
    repeat (13) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    repeat (2) @(negedge clk);
    check_outputs_zero("rst_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
